fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. It owns the architectural PC register and drives the instruction-memory address. It checks the fetch address for AdEL and latches the IF/ID pipeline register consumed by the decode stage. Its next-PC input is the redirect computed in decode by the branch/jump next-PC logic. Exception entry (interrupt/exception vector) and `eret` return are applied here.

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_check.sv | 24 ++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT_DEF   = 32'h0000_6ffc;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_NONE = 5'd0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        bd;
    logic        exc;
    logic [4:0]  exccode;
  } if_id_t;

  // Misaligned or outside the instruction window; comparisons are unsigned.
  function automatic logic fetch_addr_bad(input logic [31:0] pc, input logic [31:0] base,
                                          input logic [31:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/fetch_stage_check.sv
// Combinational AdEL check on the fetch address; a bad fetch becomes a nop.
module fetch_check
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEF
) (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_instr,
  output logic        o_exc,
  output logic [4:0]  o_exccode
);

  logic w_bad;

  always_comb begin
    w_bad     = fetch_addr_bad(i_pc, IM_BASE, IM_LIMIT);
    o_instr   = w_bad ? 32'h0 : i_instr;
    o_exc     = w_bad;
    o_exccode = w_bad ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, checks the fetch address and latches IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] IM_BASE    = IM_BASE_DEF,
  parameter logic [31:0] IM_LIMIT   = IM_LIMIT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_exc_req,
  input  logic        i_eret_go,
  input  logic [31:0] i_epc,
  input  logic        i_npc_en,
  input  logic [31:0] i_npc,
  input  logic        i_id_is_jump,
  input  logic [31:0] i_im_rdata,
  output logic [31:0] o_im_addr,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc4,
  output logic        o_id_bd,
  output logic        o_id_exc,
  output logic [4:0]  o_id_exccode
);

  logic [31:0] r_pc;
  if_id_t      r_if_id;

  logic [31:0] w_pc4;
  logic [31:0] w_instr;
  logic        w_exc;
  logic [4:0]  w_exccode;

  assign w_pc4 = r_pc + 32'd4;

  fetch_check #(
    .IM_BASE  (IM_BASE),
    .IM_LIMIT (IM_LIMIT)
  ) u_fetch_check (
    .i_pc      (r_pc),
    .i_instr   (i_im_rdata),
    .o_instr   (w_instr),
    .o_exc     (w_exc),
    .o_exccode (w_exccode)
  );

  // Priority: exception entry > stall > eret > redirect > sequential.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc    <= PC_RESET;
      r_if_id <= '0;
    end else if (i_exc_req) begin
      r_pc    <= EXC_VECTOR;
      r_if_id <= '0;
    end else if (i_stall) begin
      r_pc    <= r_pc;
      r_if_id <= r_if_id;
    end else if (i_eret_go) begin
      r_pc    <= i_epc;
      r_if_id <= '0;
    end else begin
      r_pc            <= i_npc_en ? i_npc : w_pc4;
      r_if_id.instr   <= w_instr;
      r_if_id.pc      <= r_pc;
      r_if_id.pc4     <= w_pc4;
      r_if_id.bd      <= i_id_is_jump;
      r_if_id.exc     <= w_exc;
      r_if_id.exccode <= w_exccode;
    end
  end

  assign o_im_addr    = r_pc;
  assign o_if_pc      = r_pc;
  assign o_id_instr   = r_if_id.instr;
  assign o_id_pc      = r_if_id.pc;
  assign o_id_pc4     = r_if_id.pc4;
  assign o_id_bd      = r_if_id.bd;
  assign o_id_exc     = r_if_id.exc;
  assign o_id_exccode = r_if_id.exccode;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns {16'hABCD, addr[15:0]}.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic        eret_go;
  logic [31:0] epc;
  logic        npc_en;
  logic [31:0] npc;
  logic        id_is_jump;
  logic [31:0] im_rdata;
  logic [31:0] im_addr;
  logic [31:0] if_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_bd;
  logic        id_exc;
  logic [4:0]  id_exccode;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_stall      (stall),
    .i_exc_req    (exc_req),
    .i_eret_go    (eret_go),
    .i_epc        (epc),
    .i_npc_en     (npc_en),
    .i_npc        (npc),
    .i_id_is_jump (id_is_jump),
    .i_im_rdata   (im_rdata),
    .o_im_addr    (im_addr),
    .o_if_pc      (if_pc),
    .o_id_instr   (id_instr),
    .o_id_pc      (id_pc),
    .o_id_pc4     (id_pc4),
    .o_id_bd      (id_bd),
    .o_id_exc     (id_exc),
    .o_id_exccode (id_exccode)
  );

  assign im_rdata = {16'hABCD, im_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic bd, input logic exc, input logic [4:0] code);
    check_eq({tag, "_instr"}, id_instr, instr);
    check_eq({tag, "_pc"}, id_pc, pc);
    check_eq({tag, "_pc4"}, id_pc4, (pc == 32'h0 && instr == 32'h0 && !exc) ? 32'h0 : pc + 32'd4);
    check_eq({tag, "_bd"}, {31'd0, id_bd}, {31'd0, bd});
    check_eq({tag, "_exc"}, {31'd0, id_exc}, {31'd0, exc});
    check_eq({tag, "_code"}, {27'd0, id_exccode}, {27'd0, code});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; exc_req = 1'b0; eret_go = 1'b0; epc = '0;
    npc_en = 1'b0; npc = '0; id_is_jump = 1'b0;
    #1;
    check_eq("rst_im_addr", im_addr, 32'h3000);
    check_eq("rst_if_pc", if_pc, 32'h3000);
    check_id("rst", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    #1 reset = 1'b0;

    // Free running
    step();
    check_eq("run1_addr", im_addr, 32'h3004);
    check_id("run1", 32'hABCD3000, 32'h3000, 1'b0, 1'b0, 5'd0);
    step();
    check_eq("run2_addr", im_addr, 32'h3008);
    check_id("run2", 32'hABCD3004, 32'h3004, 1'b0, 1'b0, 5'd0);

    // Jump in decode at pc=0x3008
    npc_en = 1'b1; npc = 32'h3100; id_is_jump = 1'b1;
    step();
    check_eq("jmp_addr", im_addr, 32'h3100);
    check_id("jmp", 32'hABCD3008, 32'h3008, 1'b1, 1'b0, 5'd0);
    npc_en = 1'b0; id_is_jump = 1'b0;
    step();
    check_eq("post_jmp_addr", im_addr, 32'h3104);
    check_id("post_jmp", 32'hABCD3100, 32'h3100, 1'b0, 1'b0, 5'd0);

    // Two-cycle stall; a redirect under stall must be ignored
    stall = 1'b1; npc_en = 1'b1; npc = 32'h3400;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("stall_addr", im_addr, 32'h3104);
      check_id("stall", 32'hABCD3100, 32'h3100, 1'b0, 1'b0, 5'd0);
    end
    stall = 1'b0; npc_en = 1'b0;
    step();
    check_eq("unstall_addr", im_addr, 32'h3108);
    check_id("unstall", 32'hABCD3104, 32'h3104, 1'b0, 1'b0, 5'd0);

    // eret held off by stall, then taken
    eret_go = 1'b1; epc = 32'h3200; stall = 1'b1;
    step();
    check_eq("eret_stall_addr", im_addr, 32'h3108);
    check_eq("eret_stall_idpc", id_pc, 32'h3104);
    stall = 1'b0;
    step();
    check_eq("eret_addr", im_addr, 32'h3200);
    check_id("eret", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    eret_go = 1'b0;

    // Misaligned redirect
    npc_en = 1'b1; npc = 32'h3202;
    step();
    check_eq("mis_addr", im_addr, 32'h3202);
    check_id("pre_mis", 32'hABCD3200, 32'h3200, 1'b0, 1'b0, 5'd0);
    npc = 32'h6ffc;
    step();
    check_id("mis", 32'h0, 32'h3202, 1'b0, 1'b1, 5'd4);
    npc = 32'h7000;
    step();
    check_id("limit_ok", 32'hABCD6FFC, 32'h6ffc, 1'b0, 1'b0, 5'd0);
    npc = 32'h2ffc;
    step();
    check_id("range_hi", 32'h0, 32'h7000, 1'b0, 1'b1, 5'd4);
    npc = 32'hffff_fffc;
    step();
    check_id("range_lo", 32'h0, 32'h2ffc, 1'b0, 1'b1, 5'd4);
    npc_en = 1'b0;
    step();
    check_eq("wrap_addr", im_addr, 32'h0);
    check_eq("wrap_id_pc4", id_pc4, 32'h0);

    // exc_req beats stall and redirect
    exc_req = 1'b1; stall = 1'b1; npc_en = 1'b1; npc = 32'h3300; eret_go = 1'b1;
    step();
    check_eq("exc_addr", im_addr, 32'h4180);
    check_id("exc", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    exc_req = 1'b0; stall = 1'b0; npc_en = 1'b0; eret_go = 1'b0;
    step();
    check_eq("handler_addr", im_addr, 32'h4184);
    check_eq("handler_idpc", id_pc, 32'h4180);

    // Asynchronous reset in the middle of a stall
    stall = 1'b1;
    step();
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_addr", im_addr, 32'h3000);
    check_eq("async_rst_idpc", id_pc, 32'h0);
    check_eq("async_rst_instr", id_instr, 32'h0);
    reset = 1'b0; stall = 1'b0;
    step();
    check_eq("after_rst_idpc", id_pc, 32'h3000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
